ysyx_23060203_axi_rd_arb: RTL
=============================

YSYX_23060203_AXI_RD_ARB -- requirements
Module: ysyx_23060203_axi_rd_arb

Interface
REQ-001 SHALL have parameter IFU_ARID, default 0: arid driven downstream for IFU-granted bursts.
REQ-002 SHALL have parameter LSU_ARID, default 1: arid driven downstream for LSU-granted bursts.
REQ-003 SHALL have port clock  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port ifu_r  axi_if.in  bundle: read AR/R channels from the instruction cache.
REQ-006 SHALL have port lsu_r  axi_if.in  bundle: read AR/R channels from the load/store unit.
REQ-007 SHALL have port mem_r  axi_if.out  bundle: shared read AR/R channels to memory.
REQ-008 SHALL have port grant  output  2: one-hot current owner; bit0 = IFU, bit1 = LSU, 0 when idle.

Function
REQ-009 SHALL implement FSM states IDLE, AR, R, with owner register own (IFU/LSU) and last-served register last.
REQ-010 In IDLE, SHALL sample both arvalid inputs; if either is high, SHALL latch own and enter AR next cycle.
REQ-011 Single requester in IDLE SHALL be granted; simultaneous requesters SHALL be resolved per REQ-020.
REQ-012 In AR, mem_r.arvalid/araddr/arlen/arsize/arburst SHALL mirror the owner's AR fields combinationally; arid SHALL be the owner's *_ARID parameter.
REQ-013 In AR, owner arready SHALL equal mem_r.arready; non-owner arready SHALL be 0; on mem_r.arvalid & mem_r.arready, SHALL enter R.
REQ-014 In R, mem_r.rready SHALL equal owner rready; owner rvalid/rdata/rresp/rlast SHALL mirror mem_r; non-owner rvalid SHALL be 0.
REQ-015 On mem_r.rvalid & mem_r.rready & mem_r.rlast in R, SHALL set last <= own and return to IDLE; no new grant in that same cycle.
REQ-016 Grant latency: requester arvalid high in IDLE at cycle N -> mem_r.arvalid high at cycle N+1.
REQ-017 Owner SHALL not change from AR entry until rlast handshake; arvalid from the non-owner SHALL be held off (arready 0) indefinitely.
REQ-018 Outside AR, mem_r.arvalid SHALL be 0; outside R, mem_r.rready SHALL be 0 and both requester rvalid SHALL be 0.
REQ-019 grant SHALL be one-hot of own in AR and R, 0 in IDLE.
REQ-020 Tie-break (both arvalid in IDLE): grant the requester not equal to last (round-robin) unless REQ-025 applies.
REQ-021 Single-beat bursts (arlen 0, rlast on first beat) SHALL complete AR -> R -> IDLE with no extra cycles beyond handshakes.
REQ-022 Back-to-back: requester holding arvalid after its own rlast SHALL be re-eligible in IDLE the following cycle.

Reset
REQ-023 On reset, SHALL set state IDLE, own IFU, last LSU (so IFU wins the first tie), grant 0, all downstream valid/ready outputs 0 the following cycle.
REQ-024 Reset asserted mid-burst SHALL abandon the burst immediately; recovery of the memory side is out of scope.

Configuration
REQ-025 Macro YSYX_23060203_ARB_FIXED_PRIO_EN defined: ties SHALL always grant LSU, last ignored; undefined: round-robin per REQ-020.

Verification
REQ-026 Reset then IFU arvalid, araddr 0x8000_0000, arlen 15 -> mem_r.arvalid next cycle, arid 0, 16 beats routed to IFU only, grant 01 throughout, IDLE after rlast.
REQ-027 Both arvalid in same IDLE cycle after reset -> IFU granted first, LSU granted on the cycle after IFU rlast (round-robin build); LSU first under FIXED_PRIO_EN.
REQ-028 LSU arvalid asserted mid IFU burst -> lsu arready 0 and lsu rvalid 0 until IFU rlast, then LSU AR issued with arid 1.
REQ-029 mem_r.arready held low 5 cycles in AR -> owner arready low 5 cycles, state stays AR, araddr stable.
REQ-030 Reset asserted during beat 3 of 16 -> next cycle state IDLE, grant 0, mem_r.arvalid 0, mem_r.rready 0.

Source files
------------

// File: rtl/ysyx_23060203_axi_rd_arb_if.sv
// AXI4 read-only (AR/R) channel bundle shared by the requesters and the memory port.
// "in" is the arbiter's slave-facing view, "out" is its master-facing view.
interface axi_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport in (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_23060203_axi_rd_arb.sv
// Two-master (IFU/LSU) AXI read arbiter owning the memory port for a whole burst.
// Define YSYX_23060203_ARB_FIXED_PRIO_EN to make LSU win every tie instead of round-robin.
module ysyx_23060203_axi_rd_arb #(
  parameter logic [3:0] IFU_ARID = 4'd0,
  parameter logic [3:0] LSU_ARID = 4'd1
) (
  input  logic       clock,
  input  logic       reset,
  axi_if.in          ifu_r,
  axi_if.in          lsu_r,
  axi_if.out         mem_r,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t     state_q, state_d;
  owner_t     own_q, own_d;
  owner_t     last_q, last_d;
  owner_t     tie_pick;
  logic [1:0] grant_d;
  logic       own_arvalid;
  logic       own_rready;

  assign own_arvalid = (own_q == OWN_LSU) ? lsu_r.arvalid : ifu_r.arvalid;
  assign own_rready  = (own_q == OWN_LSU) ? lsu_r.rready  : ifu_r.rready;

`ifdef YSYX_23060203_ARB_FIXED_PRIO_EN
  assign tie_pick = OWN_LSU;
`else
  assign tie_pick = (last_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
`endif

  // State, owner, last-served and grant registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      own_q   <= OWN_IFU;
      last_q  <= OWN_LSU;
      grant   <= 2'b00;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      grant   <= grant_d;
    end
  end

  // Next state and channel routing; AR/R payloads pass straight through
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;

    mem_r.arvalid = 1'b0;
    mem_r.araddr  = (own_q == OWN_LSU) ? lsu_r.araddr  : ifu_r.araddr;
    mem_r.arlen   = (own_q == OWN_LSU) ? lsu_r.arlen   : ifu_r.arlen;
    mem_r.arsize  = (own_q == OWN_LSU) ? lsu_r.arsize  : ifu_r.arsize;
    mem_r.arburst = (own_q == OWN_LSU) ? lsu_r.arburst : ifu_r.arburst;
    mem_r.arid    = (own_q == OWN_LSU) ? LSU_ARID      : IFU_ARID;
    mem_r.rready  = 1'b0;

    ifu_r.arready = 1'b0;
    lsu_r.arready = 1'b0;
    ifu_r.rvalid  = 1'b0;
    lsu_r.rvalid  = 1'b0;
    ifu_r.rdata   = mem_r.rdata;
    lsu_r.rdata   = mem_r.rdata;
    ifu_r.rresp   = mem_r.rresp;
    lsu_r.rresp   = mem_r.rresp;
    ifu_r.rlast   = mem_r.rlast;
    lsu_r.rlast   = mem_r.rlast;

    unique case (state_q)
      S_IDLE: begin
        if (ifu_r.arvalid && lsu_r.arvalid) begin
          own_d   = tie_pick;
          state_d = S_AR;
        end else if (ifu_r.arvalid || lsu_r.arvalid) begin
          own_d   = lsu_r.arvalid ? OWN_LSU : OWN_IFU;
          state_d = S_AR;
        end
      end
      S_AR: begin
        mem_r.arvalid = own_arvalid;
        if (own_q == OWN_LSU) lsu_r.arready = mem_r.arready;
        else                  ifu_r.arready = mem_r.arready;
        if (own_arvalid && mem_r.arready) state_d = S_R;
      end
      S_R: begin
        mem_r.rready = own_rready;
        if (own_q == OWN_LSU) lsu_r.rvalid = mem_r.rvalid;
        else                  ifu_r.rvalid = mem_r.rvalid;
        // Burst ends on the last beat; the next grant needs a fresh IDLE cycle
        if (mem_r.rvalid && own_rready && mem_r.rlast) begin
          last_d  = own_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    grant_d = 2'b00;
    if (state_d != S_IDLE) grant_d = (own_d == OWN_LSU) ? 2'b10 : 2'b01;
  end

endmodule
